// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment display blocks.
//   seg_t      : 7-bit active-low cathode vector {g,f,e,d,c,b,a}
//   SEG_BLANK  : all segments off
//   SEG_TABLE  : hex nibble -> active-low segment pattern (0-9, A, b, C, d, E, F)
//   idx_width  : ceil(log2(n)), never less than 1, for counters/indices
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational 4-bit hex nibble to active-low seven-segment decoder.
// Ports:
//   nibble_i : hex digit to show
//   seg_o    : cathodes {g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    // Table lookup: every 4-bit value has an entry, so no fallback is needed.
    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexes a packed hex value onto a common-anode multi-digit
// seven-segment display. An internal prescaler produces one tick every
// REFRESH_DIV+1 clocks; each tick drives the next digit. New values arrive on
// a valid/ready handshake into a one-entry pending slot and are moved into the
// displayed (shadow) copy only on the digit-0 tick, so a frame never tears.
//
// Parameters:
//   NUM_DIGITS  : digits scanned (2..8)
//   REFRESH_DIV : prescaler terminal count
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   upd_value   : packed hex digits, digit 0 in bits [3:0]
//   upd_dp      : decimal-point enables, bit i = digit i
//   upd_valid   : offer of upd_value/upd_dp
//   upd_ready   : pending slot empty
//   an          : anode selects, active low, one-cold
//   seg         : cathodes {g,f,e,d,c,b,a}, active low
//   dp          : decimal point cathode, active low
//   frame_done  : one-cycle pulse with the last digit's outputs
// Build option:
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN : blank digits above the most significant
//   nonzero nibble (digit 0 always shown, dp still honoured).
// -----------------------------------------------------------------------------
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 99999
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] upd_value,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(REFRESH_DIV + 1);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    // State
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic [IDX_W-1:0]        idx_q,        idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q,   pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q,    pend_dp_d;
    logic                    pend_full_q,  pend_full_d;
    logic [NUM_DIGITS-1:0]   an_q,         an_d;
    seg_t                    seg_q,        seg_d;
    logic                    dp_q,         dp_d;
    logic                    frame_done_q, frame_done_d;

    // Combinational helpers
    logic                    tick_s;
    logic                    commit_s;
    logic                    xfer_s;
    logic [4*NUM_DIGITS-1:0] disp_val_s;
    logic [NUM_DIGITS-1:0]   disp_dp_s;
    logic [3:0]              nibble_s;
    seg_t                    dec_seg_s;
    logic                    blank_s;

    assign tick_s    = (cnt_q == CNT_LAST);
    assign commit_s  = tick_s && (idx_q == '0) && pend_full_q;
    assign xfer_s    = upd_valid && !pend_full_q;
    assign upd_ready = !pend_full_q;

    // On a commit tick digit 0 is drawn straight from the pending slot so the
    // new frame starts on the very tick it is committed.
    always_comb begin
        disp_val_s = commit_s ? pend_val_q : shadow_val_q;
        disp_dp_s  = commit_s ? pend_dp_q  : shadow_dp_q;
        nibble_s   = disp_val_s[4*int'(idx_q) +: 4];
    end

    hex_to_7seg u_dec (
        .nibble_i (nibble_s),
        .seg_o    (dec_seg_s)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_s;

    // Position of the most significant nonzero nibble; 0 when the value is 0,
    // which keeps digit 0 visible.
    always_comb begin
        msd_s = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_val_s[4*i +: 4] != 4'h0) begin
                msd_s = IDX_W'(i);
            end else begin
                msd_s = msd_s;
            end
        end
    end

    assign blank_s = (idx_q > msd_s);
`else
    assign blank_s = 1'b0;
`endif

    // Next-state for prescaler, scan index, handshake slot and display outputs.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_full_d  = pend_full_q;
        an_d         = an_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;

        if (tick_s) begin
            cnt_d        = '0;
            an_d         = ~(AN_ONE << idx_q);
            seg_d        = blank_s ? SEG_BLANK : dec_seg_s;
            dp_d         = ~disp_dp_s[idx_q];
            frame_done_d = (idx_q == IDX_LAST);
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        // commit_s needs a full slot and xfer_s an empty one: never both.
        if (commit_s) begin
            shadow_val_d = pend_val_q;
            shadow_dp_d  = pend_dp_q;
            pend_full_d  = 1'b0;
        end else if (xfer_s) begin
            pend_val_d  = upd_value;
            pend_dp_d   = upd_dp;
            pend_full_d = 1'b1;
        end else begin
            pend_full_d = pend_full_q;
        end
    end

    // State register with synchronous reset; reset blanks the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_full_q  <= pend_full_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=3
// (one tick every 4 clocks). Inputs change and outputs are sampled on the
// falling edge. Expected segment codes are written out by hand.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int RD = 3;

    localparam logic [15:0] S0 = 16'h40;
    localparam logic [15:0] S1 = 16'h79;
    localparam logic [15:0] S2 = 16'h24;
    localparam logic [15:0] S3 = 16'h30;
    localparam logic [15:0] S4 = 16'h19;
    localparam logic [15:0] S5 = 16'h12;
    localparam logic [15:0] SA = 16'h08;
    localparam logic [15:0] SB = 16'h03;
    localparam logic [15:0] SC = 16'h46;
    localparam logic [15:0] SD = 16'h21;
    localparam logic [15:0] SX = 16'h7F;

    logic            clk;
    logic            rst;
    logic [4*ND-1:0] upd_value;
    logic [ND-1:0]   upd_dp;
    logic            upd_valid;
    logic            upd_ready;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_done;

    int checks;
    int failures;

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_value  (upd_value),
        .upd_dp     (upd_dp),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: anodes, segments, dp, ready, frame_done.
    task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [15:0] e_seg,
                           input logic e_dp, input logic e_rdy, input logic e_fd);
        chk({tag, ".an"},  {12'h0, an},         {12'h0, e_an});
        chk({tag, ".seg"}, {9'h0, seg},         e_seg);
        chk({tag, ".dp"},  {15'h0, dp},         {15'h0, e_dp});
        chk({tag, ".rdy"}, {15'h0, upd_ready},  {15'h0, e_rdy});
        chk({tag, ".fd"},  {15'h0, frame_done}, {15'h0, e_fd});
    endtask

    logic [15:0] lz_hi;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        upd_value = 16'h0000;
        upd_dp    = 4'b0000;
        upd_valid = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        lz_hi = SX;
`else
        lz_hi = S0;
`endif

        // 1. reset and first tick
        adv(2);
        chk_out("rst", 4'hF, SX, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        adv(3);
        chk_out("pre_tick", 4'hF, SX, 1'b1, 1'b1, 1'b0);
        adv(1);
        chk_out("tick0", 4'hE, S0, 1'b1, 1'b1, 1'b0);

        // 2. scan order with 1234 / dp 0010
        upd_value = 16'h1234;
        upd_dp    = 4'b0010;
        upd_valid = 1'b1;
        adv(1);
        chk("xfer1.rdy", {15'h0, upd_ready}, 16'h0);
        upd_valid = 1'b0;
        adv(3);
        chk_out("old_d1", 4'hD, S0, 1'b1, 1'b0, 1'b0);
        adv(8);
        chk_out("old_d3", 4'h7, S0, 1'b1, 1'b0, 1'b1);
        adv(1);
        chk("fd_pulse_end", {15'h0, frame_done}, 16'h0);
        adv(3);
        chk_out("f1_d0", 4'hE, S4, 1'b1, 1'b1, 1'b0);
        adv(3);
        chk("f1_d0_hold", {12'h0, an}, 16'hE);
        adv(1);
        chk_out("f1_d1", 4'hD, S3, 1'b0, 1'b1, 1'b0);

        // 3. mid-frame update ABCD while digit 1 shows
        upd_value = 16'hABCD;
        upd_dp    = 4'b0000;
        upd_valid = 1'b1;
        adv(1);
        chk("xfer2.rdy", {15'h0, upd_ready}, 16'h0);

        // 4. backpressure: 5555 offered while the slot holds ABCD
        upd_value = 16'h5555;
        upd_dp    = 4'b1001;
        adv(3);
        chk_out("f1_d2", 4'hB, S2, 1'b1, 1'b0, 1'b0);
        adv(4);
        chk_out("f1_d3", 4'h7, S1, 1'b1, 1'b0, 1'b1);
        adv(4);
        chk_out("f2_d0", 4'hE, SD, 1'b1, 1'b1, 1'b0);
        adv(1);
        chk("xfer3.rdy", {15'h0, upd_ready}, 16'h0);
        upd_valid = 1'b0;
        adv(3);
        chk_out("f2_d1", 4'hD, SC, 1'b1, 1'b0, 1'b0);
        adv(8);
        chk_out("f2_d3", 4'h7, SA, 1'b1, 1'b0, 1'b1);
        adv(4);
        chk_out("f3_d0", 4'hE, S5, 1'b0, 1'b1, 1'b0);
        adv(4);
        chk_out("f3_d1", 4'hD, S5, 1'b1, 1'b1, 1'b0);

        // 5. reset mid-frame with the slot full
        upd_value = 16'h9876;
        upd_dp    = 4'b1111;
        upd_valid = 1'b1;
        adv(1);
        chk("xfer4.rdy", {15'h0, upd_ready}, 16'h0);
        upd_valid = 1'b0;
        adv(3);
        chk_out("f3_d2", 4'hB, S5, 1'b1, 1'b0, 1'b0);
        adv(1);
        rst = 1'b1;
        adv(1);
        chk_out("mid_rst", 4'hF, SX, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        adv(3);
        chk("post_rst_hold", {12'h0, an}, 16'hF);
        adv(1);
        chk_out("post_rst_d0", 4'hE, S0, 1'b1, 1'b1, 1'b0);

        // 6. leading zeros: 0050
        upd_value = 16'h0050;
        upd_dp    = 4'b0000;
        upd_valid = 1'b1;
        adv(1);
        chk("xfer5.rdy", {15'h0, upd_ready}, 16'h0);
        upd_valid = 1'b0;
        adv(15);
        chk_out("lz_d0", 4'hE, S0, 1'b1, 1'b1, 1'b0);
        adv(4);
        chk_out("lz_d1", 4'hD, S5, 1'b1, 1'b1, 1'b0);
        adv(4);
        chk_out("lz_d2", 4'hB, lz_hi, 1'b1, 1'b1, 1'b0);
        adv(4);
        chk_out("lz_d3", 4'h7, lz_hi, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
